// File: rtl/shot_judge.sv
// Basketball shot judge: watches ball positions after a launch and decides made/missed.
// Optional STREAK_BONUS_EN adds a third point on every third consecutive make.
module shot_judge #(
  parameter logic [9:0]  RIM_Y      = 10'd180,
  parameter logic [9:0]  RIM_XL     = 10'd540,
  parameter logic [9:0]  RIM_XR     = 10'd600,
  parameter logic [9:0]  FLOOR_Y    = 10'd470,
  parameter logic [11:0] MAX_FRAMES = 12'd600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       pos_valid,
  input  logic       launch,
  output logic       made,
  output logic       missed,
  output logic [7:0] score_bcd,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for launch; positions ignored
  // FLIGHT | tracking the ball, judging each position update
  // RESULT | one cycle, made or missed pulse is high
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [11:0] frame_cnt;
  logic [9:0]  prev_y;
  logic        prev_y_valid;
  logic        make_hit;
  logic        miss_hit;
  logic        out_of_play;
  logic [1:0]  add_pts;

  function automatic logic [7:0] bcd_add_sat(input logic [7:0] s, input logic [1:0] pts);
    logic [4:0] lo;
    logic [4:0] hi;
    lo = {1'b0, s[3:0]} + {3'b000, pts};
    hi = {1'b0, s[7:4]};
    if (lo > 5'd9) begin
      lo = lo - 5'd10;
      hi = hi + 5'd1;
    end
    if (hi > 5'd9) return 8'h99;
    return {hi[3:0], lo[3:0]};
  endfunction

  always_comb begin
    make_hit = (state == FLIGHT) && pos_valid && prev_y_valid &&
               (prev_y < RIM_Y) && (ball_y >= RIM_Y) &&
               (ball_x >= RIM_XL) && (ball_x <= RIM_XR);
    out_of_play = (ball_y >= FLOOR_Y) || (ball_x > 10'd639) ||
                  (frame_cnt == MAX_FRAMES - 12'd1);
    // A ball that crosses the rim and lands out of play in the same update still counts.
    miss_hit = (state == FLIGHT) && pos_valid && out_of_play && !make_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = FLIGHT;
      FLIGHT:  if (make_hit || miss_hit) next_state = RESULT;
      RESULT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef STREAK_BONUS_EN
  logic [1:0] streak;

  assign add_pts = (streak == 2'd2) ? 2'd3 : 2'd2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak <= 2'd0;
    end else if (make_hit) begin
      streak <= (streak == 2'd2) ? 2'd0 : streak + 2'd1;
    end else if (miss_hit) begin
      streak <= 2'd0;
    end
  end
`else
  assign add_pts = 2'd2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt    <= 12'd0;
      prev_y       <= 10'd0;
      prev_y_valid <= 1'b0;
    end else if (state == IDLE && launch) begin
      frame_cnt    <= 12'd0;
      prev_y_valid <= 1'b0;
    end else if (state == FLIGHT && pos_valid) begin
      frame_cnt    <= frame_cnt + 12'd1;
      prev_y       <= ball_y;
      prev_y_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      made      <= 1'b0;
      missed    <= 1'b0;
      score_bcd <= 8'h00;
    end else begin
      made   <= make_hit;
      missed <= miss_hit;
      if (make_hit) score_bcd <= bcd_add_sat(score_bcd, add_pts);
    end
  end

endmodule

// File: tb/tb_shot_judge.sv
// Directed bench for shot_judge; builds with or without STREAK_BONUS_EN.
module tb_shot_judge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ball_x = 10'd0;
  logic [9:0] ball_y = 10'd0;
  logic       pos_valid = 1'b0;
  logic       launch = 1'b0;
  logic       made;
  logic       missed;
  logic [7:0] score_bcd;
  logic       busy;

  int compared = 0;
  int mismatched = 0;
  int pts_m = 0;
  int streak_m = 0;

  shot_judge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .pos_valid (pos_valid),
    .launch    (launch),
    .made      (made),
    .missed    (missed),
    .score_bcd (score_bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_score();
    int p;
    p = (pts_m > 99) ? 99 : pts_m;
    return 8'(((p / 10) * 16) + (p % 10));
  endfunction

  function automatic void model_make();
`ifdef STREAK_BONUS_EN
    if (streak_m == 2) begin
      pts_m += 3;
      streak_m = 0;
    end else begin
      pts_m += 2;
      streak_m++;
    end
`else
    pts_m += 2;
`endif
    if (pts_m > 99) pts_m = 99;
  endfunction

  function automatic void model_miss();
    streak_m = 0;
  endfunction

  function automatic void model_reset();
    pts_m = 0;
    streak_m = 0;
  endfunction

  // All tasks are entered and left at a falling edge.
  task automatic pos(input logic [9:0] x, input logic [9:0] y);
    ball_x = x;
    ball_y = y;
    pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
  endtask

  task automatic do_launch();
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic em, input logic emi);
    check({tag, ".made"}, {7'd0, made}, {7'd0, em});
    check({tag, ".missed"}, {7'd0, missed}, {7'd0, emi});
    check({tag, ".busy_result"}, {7'd0, busy}, 8'd1);
    check({tag, ".score"}, score_bcd, exp_score());
    @(negedge clk);
    check({tag, ".made_clr"}, {7'd0, made}, 8'd0);
    check({tag, ".missed_clr"}, {7'd0, missed}, 8'd0);
    check({tag, ".busy_idle"}, {7'd0, busy}, 8'd0);
  endtask

  task automatic make_shot(input string tag);
    do_launch();
    pos(10'd570, 10'd150);
    pos(10'd575, 10'd190);
    model_make();
    check_result(tag, 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst.score", score_bcd, 8'h00);
    check("rst.made", {7'd0, made}, 8'd0);
    check("rst.missed", {7'd0, missed}, 8'd0);
    check("rst.busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic make
    do_launch();
    check("make1.busy_launch", {7'd0, busy}, 8'd1);
    pos(10'd570, 10'd150);
    check("make1.no_early", {7'd0, made | missed}, 8'd0);
    pos(10'd575, 10'd190);
    model_make();
    check("make1.score_const", score_bcd, 8'h02);
    check_result("make1", 1'b1, 1'b0);

    // floor miss
    do_launch();
    pos(10'd300, 10'd400);
    pos(10'd310, 10'd475);
    model_miss();
    check_result("floor_miss", 1'b0, 1'b1);
    check("floor_miss.score_const", score_bcd, 8'h02);

    // position in IDLE is ignored and prev_y_valid cleared by launch
    pos(10'd570, 10'd150);
    check("idle_pos.busy", {7'd0, busy}, 8'd0);
    do_launch();
    pos(10'd575, 10'd190);
    check("idle_pos.no_make", {7'd0, made | missed}, 8'd0);
    check("idle_pos.busy_flight", {7'd0, busy}, 8'd1);
    pos(10'd575, 10'd100);
    pos(10'd575, 10'd200);
    model_make();
    check_result("idle_pos", 1'b1, 1'b0);

    // launch during flight does not restart tracking
    do_launch();
    pos(10'd570, 10'd150);
    do_launch();
    pos(10'd575, 10'd190);
    model_make();
    check_result("relaunch", 1'b1, 1'b0);

    // make and floor in the same update -> make
    do_launch();
    pos(10'd560, 10'd150);
    pos(10'd560, 10'd480);
    model_make();
    check_result("make_floor", 1'b1, 1'b0);

    // off-screen miss
    do_launch();
    pos(10'd700, 10'd100);
    model_miss();
    check_result("offscreen", 1'b0, 1'b1);

    // rim edges: left and right inclusive, y exactly on the rim
    do_launch();
    pos(10'd540, 10'd179);
    pos(10'd540, 10'd180);
    model_make();
    check_result("edge_xl", 1'b1, 1'b0);
    do_launch();
    pos(10'd600, 10'd150);
    pos(10'd600, 10'd190);
    model_make();
    check_result("edge_xr", 1'b1, 1'b0);
    check("carry.score_after_6", score_bcd, exp_score());

    // just outside the hoop, and prev_y already on the rim: no make
    do_launch();
    pos(10'd539, 10'd150);
    pos(10'd539, 10'd190);
    check("edge_out_left", {7'd0, made | missed}, 8'd0);
    pos(10'd601, 10'd150);
    pos(10'd601, 10'd190);
    check("edge_out_right", {7'd0, made | missed}, 8'd0);
    pos(10'd570, 10'd180);
    pos(10'd570, 10'd200);
    check("prev_on_rim", {7'd0, made | missed}, 8'd0);
    pos(10'd570, 10'd470);
    model_miss();
    check_result("edge_floor", 1'b0, 1'b1);

    // flight timeout on the MAX_FRAMES-th update
    do_launch();
    for (int i = 0; i < 599; i++) pos(10'd100, 10'd100);
    check("timeout.not_yet", {7'd0, made | missed}, 8'd0);
    check("timeout.busy", {7'd0, busy}, 8'd1);
    pos(10'd100, 10'd100);
    model_miss();
    check_result("timeout", 1'b0, 1'b1);

    // reset mid-flight abandons the shot
    do_launch();
    pos(10'd570, 10'd150);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("midrst.busy", {7'd0, busy}, 8'd0);
    pos(10'd575, 10'd190);
    check("midrst.made", {7'd0, made}, 8'd0);
    check("midrst.busy2", {7'd0, busy}, 8'd0);
    check("midrst.score", score_bcd, 8'h00);

    // reset wins over launch and pos_valid
    rst_n = 1'b0;
    launch = 1'b1;
    ball_x = 10'd575;
    ball_y = 10'd190;
    pos_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    launch = 1'b0;
    pos_valid = 1'b0;
    check("rst_prio.busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    check("rst_prio.busy2", {7'd0, busy}, 8'd0);

    // consecutive makes from zero
    make_shot("seq1");
    check("seq1.const", score_bcd, 8'h02);
    make_shot("seq2");
    check("seq2.const", score_bcd, 8'h04);
    make_shot("seq3");
`ifdef STREAK_BONUS_EN
    check("seq3.const", score_bcd, 8'h07);
`else
    check("seq3.const", score_bcd, 8'h06);
`endif
    make_shot("seq4");
`ifdef STREAK_BONUS_EN
    check("seq4.const", score_bcd, 8'h09);
`else
    check("seq4.const", score_bcd, 8'h08);
`endif

    // saturation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 49; i++) make_shot("sat_fill");
`ifndef STREAK_BONUS_EN
    check("sat.98", score_bcd, 8'h98);
`endif
    make_shot("sat_top");
    check("sat.99", score_bcd, 8'h99);
    make_shot("sat_hold");
    check("sat.hold", score_bcd, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shot_judge.md
SHOT_JUDGE -- requirements
Module: shot_judge

Interface
REQ-001 Parameter RIM_Y, default 10'd180, screen row of the hoop rim line.
REQ-002 Parameter RIM_XL, default 10'd540, leftmost column counted as inside the hoop.
REQ-003 Parameter RIM_XR, default 10'd600, rightmost column counted as inside the hoop.
REQ-004 Parameter FLOOR_Y, default 10'd470, row at or beyond which the ball is on the floor.
REQ-005 Parameter MAX_FRAMES, default 12'd600, maximum flight length in position updates.
REQ-006 clk  in  1  system clock, 100 MHz, sole clock.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 ball_x  in  10  ball column from the kinematic stage.
REQ-009 ball_y  in  10  ball row from the kinematic stage; row increases downward.
REQ-010 pos_valid  in  1  one-cycle strobe: ball_x/ball_y hold a new position.
REQ-011 launch  in  1  one-cycle strobe: a shot has just been released.
REQ-012 made  out  1  one-cycle pulse when a basket is judged.
REQ-013 missed  out  1  one-cycle pulse when a miss is judged.
REQ-014 score_bcd  out  8  total points as two BCD digits, 00-99.
REQ-015 busy  out  1  high while a shot is being judged.

Function
REQ-016 FSM states: IDLE, FLIGHT, RESULT; the state register is 2 bits wide.
REQ-017 IDLE: on launch, go to FLIGHT, clear the frame counter, and clear prev_y_valid.
REQ-018 FLIGHT: each pos_valid increments the 12-bit frame counter and stores ball_y in prev_y, setting prev_y_valid.
REQ-019 Make condition: pos_valid, prev_y_valid, prev_y < RIM_Y, ball_y >= RIM_Y, and RIM_XL <= ball_x <= RIM_XR.
REQ-020 Miss condition: pos_valid and (ball_y >= FLOOR_Y, or ball_x > 10'd639, or frame counter == MAX_FRAMES-1), and the make condition is false.
REQ-021 If the make and miss conditions are true in the same update, the result is a make.
REQ-022 On make or miss, go to RESULT; the made or missed pulse is asserted in the cycle after the qualifying pos_valid.
REQ-023 RESULT lasts exactly one cycle, then goes to IDLE; busy is high in FLIGHT and RESULT.
REQ-024 launch in FLIGHT or RESULT is ignored.
REQ-025 pos_valid in IDLE is ignored and does not update prev_y.
REQ-026 A make adds 2 to score_bcd in BCD, with a decimal carry between the digits.
REQ-027 score_bcd saturates at 8'h99; it never wraps.
REQ-028 made and missed are never high together, and are never high outside RESULT.

Reset
REQ-029 With rst_n low at a clk edge: state=IDLE, score_bcd=8'h00, made=0, missed=0, busy=0, frame counter=0, prev_y=0, prev_y_valid=0, streak=0.
REQ-030 Reset during FLIGHT abandons the shot with no pulse; the block then waits for a new launch.
REQ-031 Reset takes priority over launch and pos_valid in the same cycle.

Configuration
REQ-032 Macro STREAK_BONUS_EN controls the streak bonus.
REQ-033 With STREAK_BONUS_EN defined, a 2-bit streak counter increments on a make and clears on a miss.
REQ-034 With STREAK_BONUS_EN defined, a make that brings the streak to 3 adds 3 points instead of 2, and the streak returns to 0.
REQ-035 Without STREAK_BONUS_EN, no streak logic is built and every make adds 2.
REQ-036 Saturation per REQ-027 applies in both builds.

Verification
REQ-037 launch; pos_valid with (570,150) then (575,190) -> made pulse 1 cycle after the 2nd strobe; score_bcd 00->02; busy low 2 cycles after the 2nd strobe.
REQ-038 launch; pos_valid with (300,400) then (310,475) -> missed pulse; score unchanged.
REQ-039 Set score to 98 with 4 makes per REQ-037 after 45 prior makes: score 98->99, another make stays at 99; without STREAK_BONUS_EN.
REQ-040 launch; MAX_FRAMES pos_valid strobes at (100,100) -> missed on the 600th strobe.
REQ-041 rst_n low mid-FLIGHT, then (575,190) pos_valid -> no pulse, busy=0, score=00.
REQ-042 With STREAK_BONUS_EN, three consecutive makes -> score 02, 04, 07; a 4th make -> 09.
